// File: rtl/sgdmac_pkg.sv
// ---------------------------------------------------------------------------
// sgdmac_pkg
// Shared types and constants for the SGDMAC descriptor fetcher.
//   state_e    : descriptor-walker FSM states
//   W_*        : word index of each field inside a four-word descriptor
//   DESC_WORDS : words per descriptor; WIDX_W is the width of a word index
// ---------------------------------------------------------------------------
package sgdmac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        EVAL,
        OUT,
        NEXT
    } state_e;

    localparam int DESC_WORDS = 4;
    localparam int WIDX_W     = $clog2(DESC_WORDS);

    localparam logic [WIDX_W-1:0] W_SRC  = WIDX_W'(0);
    localparam logic [WIDX_W-1:0] W_DST  = WIDX_W'(1);
    localparam logic [WIDX_W-1:0] W_LEN  = WIDX_W'(2);
    localparam logic [WIDX_W-1:0] W_NEXT = WIDX_W'(3);

endpackage : sgdmac_pkg

// File: rtl/sgdmac_desc_fetcher.sv
// ---------------------------------------------------------------------------
// sgdmac_desc_fetcher
// Scatter-gather descriptor walker. From a software pointer it reads the four
// descriptor words {src, dst, len, next}, hands non-empty descriptors to the
// data engine and follows next until a null pointer, an error or a stop.
//
// Ports
//   clk, rst_n           : clock, synchronous active-low reset
//   start_i/start_ptr_i  : begin a walk at a word-aligned pointer (idle only)
//   stop_i               : end the walk at the next descriptor boundary
//   busy_o/done_o/err_o  : walk status; done_o pulses, err_o is sticky
//   desc_cnt_o           : descriptors emitted since the last accepted start
//   req_*                : word read requests (valid/ready, address)
//   rsp_*                : read data, returned in request order
//   desc_*               : descriptor output to the data engine
// ---------------------------------------------------------------------------
module sgdmac_desc_fetcher
    import sgdmac_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int LEN_W     = 16,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [DATA_SIZE-1:0] start_ptr_i,
    input  logic                 stop_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [CNT_W-1:0]     desc_cnt_o,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    output logic [DATA_SIZE-1:0] req_addr_o,
    input  logic                 rsp_valid_i,
    output logic                 rsp_ready_o,
    input  logic [DATA_SIZE-1:0] rsp_data_i,
    output logic                 desc_valid_o,
    input  logic                 desc_ready_i,
    output logic [DATA_SIZE-1:0] desc_src_o,
    output logic [DATA_SIZE-1:0] desc_dst_o,
    output logic [LEN_W-1:0]     desc_len_o
);

    localparam logic [WIDX_W-1:0] LAST_WIDX = WIDX_W'(DESC_WORDS - 1);

    state_e               r_state;
    state_e               w_next_state;
    logic [WIDX_W-1:0]    r_widx;
    logic [DATA_SIZE-1:0] r_ptr;
    logic [DATA_SIZE-1:0] r_src;
    logic [DATA_SIZE-1:0] r_dst;
    logic [LEN_W-1:0]     r_len;
    logic [DATA_SIZE-1:0] r_next;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_err;
    logic                 r_done;
    logic                 r_stop_pend;
    logic                 w_start_ok;
    logic                 w_next_null;
    logic                 w_next_misaligned;
    logic [DATA_SIZE-1:0] w_req_addr;

    assign w_start_ok        = start_i && (start_ptr_i[1:0] == 2'b00);
    assign w_next_null       = (r_next == '0);
    assign w_next_misaligned = (r_next[1:0] != 2'b00);
    // Word offset of the current request; the add wraps modulo 2^DATA_SIZE.
    assign w_req_addr        = r_ptr + DATA_SIZE'({r_widx, 2'b00});

    // NOTE: state register uses non-blocking assignment so every flop in this
    // module samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: next state takes its default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_start_ok) w_next_state = REQ;
            REQ:  if (req_ready_i && r_widx == LAST_WIDX) w_next_state = RESP;
            RESP: if (rsp_valid_i && r_widx == LAST_WIDX) w_next_state = EVAL;
            EVAL: w_next_state = (r_len == '0) ? NEXT : OUT;
            OUT:  if (desc_ready_i) w_next_state = NEXT;
            NEXT: begin
                if (r_stop_pend || w_next_null || w_next_misaligned)
                    w_next_state = IDLE;
                else
                    w_next_state = REQ;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath. The descriptor fields are plain registers (no memory array),
    // so all of them take the reset value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_widx      <= '0;
            r_ptr       <= '0;
            r_src       <= '0;
            r_dst       <= '0;
            r_len       <= '0;
            r_next      <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_stop_pend <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // A stop is only remembered here; it takes effect in NEXT so a
            // request/response group is never split.
            if (r_state != IDLE && stop_i) r_stop_pend <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_ptr       <= start_ptr_i;
                        r_widx      <= '0;
                        r_cnt       <= '0;
                        r_err       <= 1'b0;
                        r_stop_pend <= 1'b0;
                    end else if (start_i) begin
                        r_err  <= 1'b1;
                        r_done <= 1'b1;
                    end
                end
                REQ: if (req_ready_i) r_widx <= r_widx + 1'b1;
                RESP: begin
                    if (rsp_valid_i) begin
                        case (r_widx)
                            W_SRC:   r_src  <= rsp_data_i;
                            W_DST:   r_dst  <= rsp_data_i;
                            W_LEN:   r_len  <= rsp_data_i[LEN_W-1:0];
                            W_NEXT:  r_next <= rsp_data_i;
                            default: ;
                        endcase
                        r_widx <= r_widx + 1'b1;
                    end
                end
                OUT: if (desc_ready_i) r_cnt <= r_cnt + 1'b1;
                NEXT: begin
                    if (r_stop_pend || w_next_null) begin
                        r_done <= 1'b1;
                    end else if (w_next_misaligned) begin
                        r_err  <= 1'b1;
                        r_done <= 1'b1;
                    end else begin
                        r_ptr  <= r_next;
                        r_widx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o       = (r_state != IDLE);
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign desc_cnt_o   = r_cnt;
    assign req_valid_o  = (r_state == REQ);
    assign req_addr_o   = w_req_addr;
    assign rsp_ready_o  = (r_state == RESP);
    assign desc_valid_o = (r_state == OUT);
    assign desc_src_o   = r_src;
    assign desc_dst_o   = r_dst;
    assign desc_len_o   = r_len;

endmodule : sgdmac_desc_fetcher

// File: doc/sgdmac_desc_fetcher.md
Name: sgdmac_desc_fetcher

Overview:
Scatter-gather descriptor walker that feeds the descriptor input of the SGDMAC read-request arbiter. Starting from a software-supplied pointer, it issues four word-address read requests per descriptor and collects the four returned words {src, dst, len, next}. It hands each non-empty descriptor to the data engine over valid/ready, then follows next until it reads a null pointer.

Parameters:
DATA_SIZE, 32, width of addresses, request payload and response data
LEN_W, 16, width of the descriptor byte-length field (word2[LEN_W-1:0])
CNT_W, 16, width of the emitted-descriptor counter

Ports:
clk  in  1  clock
rst_n  in  1  reset
start_i  in  1  single-cycle pulse; begins a chain walk, ignored unless idle
start_ptr_i  in  DATA_SIZE  address of first descriptor, sampled on start_i
stop_i  in  1  pulse; requests termination at the next descriptor boundary
busy_o  out  1  high from accepted start until return to IDLE
done_o  out  1  one-cycle pulse on normal or stopped completion
err_o  out  1  sticky misalignment error, cleared by an accepted start
desc_cnt_o  out  CNT_W  number of descriptors emitted since the last start
req_valid_o  out  1  read request valid (to arbiter descriptor_valid_i)
req_ready_i  in  1  read request ready (from arbiter descriptor_ready_o)
req_addr_o  out  DATA_SIZE  word address of request
rsp_valid_i  in  1  read data valid, in request order
rsp_ready_o  out  1  read data ready
rsp_data_i  in  DATA_SIZE  read data
desc_valid_o  out  1  descriptor valid to data engine
desc_ready_i  in  1  descriptor ready
desc_src_o  out  DATA_SIZE  source address
desc_dst_o  out  DATA_SIZE  destination address
desc_len_o  out  LEN_W  byte length

Behaviour:
- Reset and clock: rst_n is a synchronous, active-low reset; clk is the clock. Reset values: state IDLE; all valid, ready, busy_o, done_o and err_o outputs 0; desc_cnt_o 0; ptr 0; descriptor registers 0. Reset mid-walk abandons the walk. Outstanding responses are the upstream's responsibility.
- State IDLE:
  - start_i with start_ptr_i[1:0]==0: ptr<=start_ptr_i, desc_cnt<=0, err<=0, stop_pend<=0, go to REQ.
  - start_i with start_ptr_i[1:0]!=0: err_o<=1, done_o pulse, stay in IDLE.
- State REQ:
  - req_valid_o=1 and req_addr_o=ptr+4*widx (widx 0..3).
  - widx advances only on req_valid_o&req_ready_i. req_addr_o must be stable while valid is held without ready.
  - After the 4th handshake go to RESP. First req_valid_o is asserted the cycle after start was accepted.
- State RESP:
  - rsp_ready_o=1; each rsp handshake stores the word into src/dst/len/next in order.
  - word2 keeps bits [LEN_W-1:0]; its upper bits are ignored.
  - After the 4th word, go to EVAL. rsp_ready_o is 0 in every other state.
- State EVAL (one cycle):
  - len==0: the descriptor is skipped (not emitted), go to NEXT.
  - Otherwise go to OUT.
- State OUT:
  - desc_valid_o=1 with src/dst/len held stable until desc_ready_i.
  - On handshake: desc_cnt++ (wraps at 2^CNT_W), go to NEXT.
- State NEXT (one cycle), in priority order:
  - stop_pend: done_o, IDLE.
  - next==0: done_o, IDLE.
  - next[1:0]!=0: err_o<=1, done_o, IDLE.
  - Otherwise: ptr<=next, widx<=0, REQ.
- stop_i is latched into stop_pend in any non-IDLE state and honoured only in NEXT, so request/response pairs are never torn. stop_i in IDLE is ignored. start_i while busy is ignored.
- Self-loop (next==ptr) is not detected; it runs until stop_i.
- Pointer arithmetic wraps modulo 2^DATA_SIZE.
- done_o and an err_o set occur in the same cycle transition. busy_o drops in the cycle done_o is high.

Decomposition:
- Package sgdmac_pkg holds:
  - state enum (IDLE, REQ, RESP, EVAL, OUT, NEXT);
  - word-index constants (W_SRC=0, W_DST=1, W_LEN=2, W_NEXT=3);
  - DESC_WORDS=4.
- Single module, no sub-module needed.

Test Plan:
- Single descriptor at 0x1000 {0x2000, 0x3000, 64, 0}, always-ready sinks:
  - requests 0x1000/1004/1008/100C;
  - one descriptor out with src 0x2000, dst 0x3000, len 64;
  - done_o one cycle later; desc_cnt_o=1; err_o=0.
- Three-descriptor chain 0x100->0x200->0x300->0, random req_ready_i/rsp_valid_i/desc_ready_i stalls:
  - three descriptors in order;
  - req_addr_o and desc fields stable during stalls;
  - desc_cnt_o=3.
- Middle descriptor with len=0 in a 3-chain:
  - only 2 descriptors emitted;
  - all 12 request addresses still issued;
  - desc_cnt_o=2.
- start_ptr_i=0x1002: err_o=1, done_o pulse, no req_valid_o.
- Chain whose next=0x206: first descriptor emitted, then err_o=1 and done_o.
- Self-looping descriptor, stop_i pulsed during RESP of the 2nd fetch:
  - 2nd descriptor still emitted;
  - then done_o;
  - desc_cnt_o=2;
  - a following start_i clears err_o and desc_cnt_o.
